// File: rtl/mem_model_hs.sv
// Behavioural off-chip memory with valid/ready request and response channels, byte-enabled writes
// and fixed or LFSR-randomised latency. Define MEM_MODEL_BOUNDS_CHECK_EN to flag out-of-range addresses.
module mem_model_hs #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DEPTH_LOG2 = 8,
    parameter int          MIN_LAT    = 1,
    parameter logic [7:0]  LAT_MASK   = 8'h0F,
    parameter int          RANDOM_LAT = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'h15
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_be,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic [1:0]              state_dbg
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BE_W);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid is never withdrawn by this model once raised, and its payload holds until the transfer.
    logic [1:0]            state;
    logic [7:0]            lfsr;
    logic [8:0]            lat_cnt;
    logic [8:0]            lat_now;
    logic                  we_q;
    logic                  oor_q;
    logic                  oor_now;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  accept;
    logic                  access;
    logic                  unused_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign o_req_ready = (state == S_IDLE);
    assign o_rsp_valid = (state == S_RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;
    assign state_dbg   = state;
    assign accept      = i_req_valid && o_req_ready;
    assign access      = (state == S_WAIT) && (lat_cnt == 9'd0);
    assign unused_addr = ^i_req_addr;

`ifdef MEM_MODEL_BOUNDS_CHECK_EN
    assign oor_now = (i_req_addr >> (LSB + DEPTH_LOG2)) != '0;
`else
    assign oor_now = 1'b0;
`endif

    // Latency uses the LFSR value before it steps on this acceptance.
    always_comb begin
        lat_now = 9'(MIN_LAT);
        if (RANDOM_LAT != 0) begin
            lat_now = 9'(MIN_LAT) + {1'b0, lfsr & LAT_MASK};
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= S_IDLE;
            lfsr    <= LFSR_SEED;
            lat_cnt <= 9'd0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= i_req_we;
                        oor_q   <= oor_now;
                        idx_q   <= i_req_addr[LSB +: DEPTH_LOG2];
                        wdata_q <= i_req_wdata;
                        be_q    <= i_req_be;
                        lat_cnt <= lat_now;
                        lfsr    <= {lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3], lfsr[7:1]};
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 9'd0) begin
                        rdata_q <= (we_q || oor_q) ? '0 : mem[idx_q];
                        err_q   <= oor_q;
                        state   <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 9'd1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately unreset; a reset during WAIT never reaches the access edge.
    always_ff @(posedge clk) begin
        if (access && we_q && !oor_q) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_model_hs.sv
// Bench for mem_model_hs: a default instance and a zero-latency, 16-word instance share one
// request driver; a word-array reference model predicts data, error flag and latency.
module tb_mem_model_hs;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;

    logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  state_a, state_b;

    logic        ready, valid, err;
    logic [31:0] rdata;
    logic [1:0]  state;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ma [256];
    logic [31:0] mb [16];
    logic [7:0]  m_lfsr = 8'h15;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    mem_model_hs dut_a (
        .clk(clk), .arst(arst),
        .i_req_valid(req_valid && !sel), .o_req_ready(ready_a),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(valid_a), .i_rsp_ready(rsp_ready && !sel),
        .o_rsp_rdata(rdata_a), .o_rsp_err(err_a), .state_dbg(state_a)
    );

    mem_model_hs #(.DEPTH_LOG2(4), .MIN_LAT(0), .RANDOM_LAT(0)) dut_b (
        .clk(clk), .arst(arst),
        .i_req_valid(req_valid && sel), .o_req_ready(ready_b),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(valid_b), .i_rsp_ready(rsp_ready && sel),
        .o_rsp_rdata(rdata_b), .o_rsp_err(err_b), .state_dbg(state_b)
    );

    assign ready = sel ? ready_b : ready_a;
    assign valid = sel ? valid_b : valid_a;
    assign err   = sel ? err_b   : err_a;
    assign rdata = sel ? rdata_b : rdata_a;
    assign state = sel ? state_b : state_a;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        logic fb;
        fb = ^(l & 8'hB8);
        return (l >> 1) | (8'(fb) << 7);
    endfunction

    // One complete transaction on instance s, with the model predicting every observable.
    task automatic xact(input bit s, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall, input bit chk_data, input string tag);
        int dlog, idx, lat, cnt;
        bit oor;
        logic [31:0] w, exp_rd;
        dlog = s ? 4 : 8;
        idx  = int'((addr >> 2) & ((32'd1 << dlog) - 1));
`ifdef MEM_MODEL_BOUNDS_CHECK_EN
        oor = (addr >> (2 + dlog)) != 0;
`else
        oor = 1'b0;
`endif
        if (s) begin
            lat = 0;
        end else begin
            lat = 1 + int'(m_lfsr & 8'h0F);
            m_lfsr = lfsr_step(m_lfsr);
        end
        w = s ? mb[idx] : ma[idx];
        exp_rd = (we || oor) ? 32'h0 : w;
        if (we && !oor) begin
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
            if (s) mb[idx] = w; else ma[idx] = w;
        end

        sel = s;
        @(negedge clk);
        check({tag, ".idle_ready"}, ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 32'($urandom); req_wdata = 32'($urandom);
        check({tag, ".busy_ready"}, ready, 0);
        cnt = 0;
        while (!valid && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, ".latency"}, cnt, lat + 1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".stall_valid"}, valid, 1);
            check({tag, ".stall_ready"}, ready, 0);
            if (chk_data) check({tag, ".stall_rdata"}, rdata, exp_rd);
        end
        if (chk_data) check({tag, ".rdata"}, rdata, exp_rd);
        check({tag, ".err"}, err, oor);
        last_rdata = rdata;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".post_valid"}, valid, 0);
        check({tag, ".post_ready"}, ready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        arst = 1'b0;

        // Reset values on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst.ready", ready, 1);
            check("rst.valid", valid, 0);
            check("rst.err", err, 0);
            check("rst.rdata", rdata, 0);
            check("rst.state", state, 0);
        end

        // Seeded latency sequence: 6, 11, 6
        xact(0, 0, 32'h0, 0, 4'h0, 0, 0, "t1.rd0");
        xact(0, 0, 32'h4, 0, 4'h0, 0, 0, "t2.rd4");
        xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1, "t3.wr_full");
        xact(0, 1, 32'h10, 32'h000000AA, 4'h1, 0, 1, "t3.wr_byte");
        xact(0, 0, 32'h10, 0, 4'h0, 0, 1, "t3.rd");
        check("t3.literal", last_rdata, 32'hDEADBEAA);

        // Zero-latency instance: fill all words, then a stalled read
        for (int i = 0; i < 16; i++) xact(1, 1, 32'(i * 4), 32'($urandom), 4'hF, 0, 1, "t4.fill");
        xact(1, 0, 32'hC, 0, 4'h0, 5, 1, "t4.stall");

        // Word 16 of a 16-word memory
        xact(1, 1, 32'h0, 32'h12345678, 4'hF, 0, 1, "t5.wr0");
        xact(1, 1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 1, "t5.wr40");
        xact(1, 0, 32'h0, 0, 4'h0, 0, 1, "t5.rd0");
`ifdef MEM_MODEL_BOUNDS_CHECK_EN
        check("t5.literal", last_rdata, 32'h12345678);
`else
        check("t5.literal", last_rdata, 32'hCAFEF00D);
`endif

        // Reset while a write waits
        xact(0, 1, 32'h8, 32'h11112222, 4'hF, 0, 1, "t6.pre");
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h99999999; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t6.in_wait", state, 1);
        arst = 1'b1;
        #1;
        check("t6.state", state, 0);
        check("t6.ready", ready, 1);
        check("t6.valid", valid, 0);
        @(negedge clk);
        arst = 1'b0;
        m_lfsr = 8'h15;
        xact(0, 0, 32'h8, 0, 4'h0, 0, 1, "t6.rd");
        check("t6.literal", last_rdata, 32'h11112222);

        // Randomised traffic on both instances
        for (int i = 0; i < 16; i++) xact(0, 1, 32'(i * 4), 32'($urandom), 4'hF, 0, 1, "rnd.fill");
        for (int i = 0; i < 40; i++) begin
            xact(0, 1'($urandom), 32'($urandom_range(0, 63)), 32'($urandom), 4'($urandom),
                 $urandom_range(0, 2), 1, "rnd.a");
            xact(1, 1'($urandom), 32'($urandom_range(0, 127)), 32'($urandom), 4'($urandom),
                 $urandom_range(0, 2), 1, "rnd.b");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
